reg_native_initiator: RTL and testbench
=======================================

// Module: reg_native_initiator
// PURPOSE
//   Initiator (master) end of the reg_native handshake. Turns one upstream register access into
//   a reg_native transaction towards an external memory/responder: drives req/addr/data, waits
//   for the ack, and returns read data or a timeout error. Sits between the regfile access
//   decoder and any external reg_native block.
// PARAMETERS
//   DATA_WIDTH  32            data bus width (up_wr_data, up_rd_data, wr_data, rd_data)
//   ADDR_WIDTH  6             address width (up_addr, addr)
//   TIMEOUT     64            max cycles spent in REQ+WAIT_ACK before error; must be >=2
//   ERR_DATA    32'hDEAD_BEEF up_rd_data value returned on timeout (truncated to DATA_WIDTH)
// PORTS
//   clk         in   1           clock, all logic on posedge
//   rst         in   1           asynchronous reset, active-high
//   up_req_vld  in   1           upstream access request valid
//   up_req_rdy  out  1           initiator can accept an upstream access (high only in IDLE)
//   up_wr       in   1           1 = write, 0 = read
//   up_addr     in   ADDR_WIDTH  access address
//   up_wr_data  in   DATA_WIDTH  write data
//   up_rsp_vld  out  1           response valid
//   up_rsp_rdy  in   1           upstream accepts response
//   up_rd_data  out  DATA_WIDTH  read data (0 for writes, ERR_DATA on timeout)
//   up_rsp_err  out  1           1 = transaction timed out
//   req_vld     out  1           reg_native request valid
//   req_rdy     in   1           reg_native request accepted
//   wr_en       out  1           reg_native write strobe
//   rd_en       out  1           reg_native read strobe
//   addr        out  ADDR_WIDTH  reg_native address
//   wr_data     out  DATA_WIDTH  reg_native write data
//   rd_data     in   DATA_WIDTH  reg_native read data, valid with ack_vld
//   ack_vld     in   1           reg_native completion (may be a 1-cycle pulse)
//   ack_rdy     out  1           initiator accepts completion
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except up_req_rdy=1; timeout counter=0; regs cleared.
//   FSM IDLE -> REQ -> WAIT_ACK -> RSP -> IDLE; all outputs registered or decoded from state.
//   IDLE: up_req_rdy=1. On up_req_vld: latch up_wr/addr/wr_data into addr/wr_data, set
//     wr_en=up_wr, rd_en=~up_wr, clear counter, go REQ. req_vld rises the cycle after acceptance.
//   REQ: req_vld=1, ack_rdy=1; addr/wr_data/wr_en/rd_en held stable. On req_rdy sampled high:
//     req_vld=0 next cycle (held for exactly the accept cycle), go WAIT_ACK. If ack_vld is
//     also high on that same edge, complete directly (go RSP).
//   WAIT_ACK: ack_rdy=1, req_vld=0. On ack_vld: capture rd_data (reads) or 0 (writes) into
//     up_rd_data, up_rsp_err=0, go RSP. wr_en/rd_en cleared on leaving WAIT_ACK.
//   Timeout: counter increments each cycle in REQ and WAIT_ACK; when it reaches TIMEOUT-1
//     without completion -> drop req_vld/wr_en/rd_en, up_rd_data=ERR_DATA, up_rsp_err=1, go RSP.
//     Ack/req_rdy on the expiry edge wins over timeout (normal completion).
//   RSP: up_rsp_vld=1, data/err held until up_rsp_vld&&up_rsp_rdy, then IDLE. ack_rdy=0;
//     late ack_vld/req_rdy arriving in RSP or IDLE is ignored and never produces a response.
//   Single outstanding transaction; no new upstream accept until response handshake completes.
//   Minimum latency (responder with 1-cycle req_rdy, ack 1 cycle later): up_req accept at T,
//     req_vld T+1, req_rdy T+2, ack_vld T+3, up_rsp_vld T+4.
//   Reset mid-transaction: immediate return to reset values; in-flight access abandoned.
// TESTING
//   1 Write addr=0x05 data=0xA5A5_0001 then read 0x05 -> up_rd_data=0xA5A5_0001, err=0;
//     write response up_rd_data=0.
//   2 Responder with ack never asserted, TIMEOUT=64 -> up_rsp_err=1, up_rd_data=0xDEAD_BEEF
//     64 cycles after REQ entry; req_vld low.
//   3 Hold up_rsp_rdy=0 for 10 cycles -> up_rsp_vld and data stable; up_req_rdy stays 0.
//   4 Back-to-back reads 0x00..0x3F after filling mem with addr*3 -> each returns addr*3, in order.
//   5 Assert rst during WAIT_ACK -> next cycle all outputs reset; late ack_vld ignored;
//     next access OK.
//   6 req_rdy delayed 5 cycles -> req_vld/addr/wr_en stable throughout, req_vld drops the
//     cycle after accept.

Source files
------------

// File: rtl/reg_native_initiator_if.sv
// reg_native initiator bus bundle: upstream access/response handshake plus the
// reg_native request/ack handshake. The master modport is the initiator's view;
// the slave modport is the view of everything around it (upstream + responder).
interface reg_native_initiator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  // upstream access side
  logic                  up_req_vld;
  logic                  up_req_rdy;
  logic                  up_wr;
  logic [ADDR_WIDTH-1:0] up_addr;
  logic [DATA_WIDTH-1:0] up_wr_data;
  logic                  up_rsp_vld;
  logic                  up_rsp_rdy;
  logic [DATA_WIDTH-1:0] up_rd_data;
  logic                  up_rsp_err;
  // reg_native side
  logic                  req_vld;
  logic                  req_rdy;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ack_vld;
  logic                  ack_rdy;

  modport master (
    input  up_req_vld, up_wr, up_addr, up_wr_data, up_rsp_rdy,
    input  req_rdy, rd_data, ack_vld,
    output up_req_rdy, up_rsp_vld, up_rd_data, up_rsp_err,
    output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy
  );

  modport slave (
    output up_req_vld, up_wr, up_addr, up_wr_data, up_rsp_rdy,
    output req_rdy, rd_data, ack_vld,
    input  up_req_rdy, up_rsp_vld, up_rd_data, up_rsp_err,
    input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy
  );
endinterface

// File: rtl/reg_native_initiator.sv
// reg_native initiator: converts one upstream register access into a reg_native
// request/ack transaction, returning read data, zero for writes, or ERR_DATA with
// an error flag when the responder does not complete within TIMEOUT cycles.
// Only one transaction is ever outstanding; every output comes from a register.
module reg_native_initiator #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 6,
  parameter int          TIMEOUT    = 64,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  reg_native_initiator_if.master  io_bus
);

  // Counter must also hold TIMEOUT itself: a req_rdy accepted on the expiry
  // edge moves to WAIT_ACK and bumps the count one past the limit.
  localparam int                    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RSP      = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_up_req_rdy;
  logic                  r_up_rsp_vld;
  logic [DATA_WIDTH-1:0] r_up_rd_data;
  logic                  r_up_rsp_err;
  logic                  r_req_vld;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_ack_rdy;

  logic                  w_complete;
  logic                  w_expire;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  // Decide whether this edge finishes the transaction: a completion always
  // beats the timeout, and ack in REQ only counts together with req_rdy.
  always_comb begin
    w_complete = 1'b0;
    w_expire   = 1'b0;
    case (r_state)
      S_REQ: begin
        w_complete = io_bus.req_rdy && io_bus.ack_vld;
        w_expire   = !io_bus.req_rdy && (r_cnt >= CNT_LAST);
      end
      S_WAIT_ACK: begin
        w_complete = io_bus.ack_vld;
        w_expire   = !io_bus.ack_vld && (r_cnt >= CNT_LAST);
      end
      default: begin
        w_complete = 1'b0;
        w_expire   = 1'b0;
      end
    endcase
    w_rsp_data = w_expire ? ERR_WORD : (r_rd_en ? io_bus.rd_data : '0);
  end

  // Transaction FSM with all bus outputs registered alongside the state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_up_req_rdy <= 1'b1;
      r_up_rsp_vld <= 1'b0;
      r_up_rd_data <= '0;
      r_up_rsp_err <= 1'b0;
      r_req_vld    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
      r_ack_rdy    <= 1'b0;
    end else if (w_complete || w_expire) begin
      r_req_vld    <= 1'b0;
      r_ack_rdy    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_up_rd_data <= w_rsp_data;
      r_up_rsp_err <= w_expire;
      r_up_rsp_vld <= 1'b1;
      r_state      <= S_RSP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.up_req_vld) begin
            r_addr       <= io_bus.up_addr;
            r_wr_data    <= io_bus.up_wr_data;
            r_wr_en      <= io_bus.up_wr;
            r_rd_en      <= ~io_bus.up_wr;
            r_cnt        <= '0;
            r_req_vld    <= 1'b1;
            r_ack_rdy    <= 1'b1;
            r_up_req_rdy <= 1'b0;
            r_state      <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (io_bus.req_rdy) begin
            r_req_vld <= 1'b0;
            r_state   <= S_WAIT_ACK;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_WAIT_ACK: begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= S_WAIT_ACK;
        end
        S_RSP: begin
          if (io_bus.up_rsp_rdy) begin
            r_up_rsp_vld <= 1'b0;
            r_up_req_rdy <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_state <= S_RSP;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_up_req_rdy <= 1'b1;
          r_up_rsp_vld <= 1'b0;
          r_req_vld    <= 1'b0;
          r_ack_rdy    <= 1'b0;
          r_wr_en      <= 1'b0;
          r_rd_en      <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.up_req_rdy = r_up_req_rdy;
  assign io_bus.up_rsp_vld = r_up_rsp_vld;
  assign io_bus.up_rd_data = r_up_rd_data;
  assign io_bus.up_rsp_err = r_up_rsp_err;
  assign io_bus.req_vld    = r_req_vld;
  assign io_bus.wr_en      = r_wr_en;
  assign io_bus.rd_en      = r_rd_en;
  assign io_bus.addr       = r_addr;
  assign io_bus.wr_data    = r_wr_data;
  assign io_bus.ack_rdy    = r_ack_rdy;

endmodule

// File: tb/tb_reg_native_initiator.sv
// Directed bench for reg_native_initiator: the bench plays both the upstream
// requester and a reg_native responder backed by a small memory, and compares
// every observed output against hand-derived expected values.
module tb_reg_native_initiator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_native_initiator_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  reg_native_initiator #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (6),
    .TIMEOUT    (64),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.master)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] mem [64];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full access. rdy_dly: cycles req_vld waits before req_rdy; ack_dly: cycles
  // after accept before ack (negative = ack on the same edge as req_rdy);
  // hold: cycles the upstream stalls the response.
  task automatic xact(input logic wr, input logic [5:0] a, input logic [31:0] d,
                      input int rdy_dly, input int ack_dly, input int hold,
                      input logic [31:0] exp_data, input int exp_lat);
    int   lat;
    logic exp_rd;
    exp_rd = ~wr;
    check_val("idle_req_rdy", {31'd0, bus.up_req_rdy}, 32'd1);
    bus.up_req_vld = 1'b1;
    bus.up_wr      = wr;
    bus.up_addr    = a;
    bus.up_wr_data = d;
    step();
    lat = 1;
    bus.up_req_vld = 1'b0;
    bus.up_wr      = ~wr;
    bus.up_addr    = ~a;
    bus.up_wr_data = ~d;
    check_val("busy_req_rdy", {31'd0, bus.up_req_rdy}, 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      check_val("req_vld_hold", {31'd0, bus.req_vld}, 32'd1);
      check_val("addr_hold", {26'd0, bus.addr}, {26'd0, a});
      check_val("wr_en_hold", {31'd0, bus.wr_en}, {31'd0, wr});
      check_val("rd_en_hold", {31'd0, bus.rd_en}, {31'd0, exp_rd});
      check_val("wdata_hold", bus.wr_data, d);
      check_val("ack_rdy_req", {31'd0, bus.ack_rdy}, 32'd1);
      step();
      lat++;
    end
    bus.req_rdy = 1'b1;
    if (ack_dly < 0) begin
      bus.ack_vld = 1'b1;
      bus.rd_data = wr ? 32'h0BAD_0BAD : mem[a];
    end
    step();
    lat++;
    bus.req_rdy = 1'b0;
    if (wr) mem[a] = d;
    if (ack_dly < 0) begin
      bus.ack_vld = 1'b0;
      bus.rd_data = 32'h0;
    end else begin
      check_val("req_vld_drop", {31'd0, bus.req_vld}, 32'd0);
      check_val("ack_rdy_wait", {31'd0, bus.ack_rdy}, 32'd1);
      for (int i = 0; i < ack_dly; i++) begin
        step();
        lat++;
      end
      bus.ack_vld = 1'b1;
      bus.rd_data = wr ? 32'h0BAD_0BAD : mem[a];
      step();
      lat++;
      bus.ack_vld = 1'b0;
      bus.rd_data = 32'h0;
    end
    for (int i = 0; i < 100 && !bus.up_rsp_vld; i++) begin
      step();
      lat++;
    end
    check_val("rsp_vld", {31'd0, bus.up_rsp_vld}, 32'd1);
    check_val("latency", lat, exp_lat);
    check_val("rd_data", bus.up_rd_data, exp_data);
    check_val("rsp_err", {31'd0, bus.up_rsp_err}, 32'd0);
    check_val("ack_rdy_rsp", {31'd0, bus.ack_rdy}, 32'd0);
    check_val("strobes_clr", {30'd0, bus.wr_en, bus.rd_en}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.ack_vld = (i == 0);
      bus.req_rdy = (i == 1);
      bus.rd_data = 32'h5555_AAAA;
      step();
      bus.ack_vld = 1'b0;
      bus.req_rdy = 1'b0;
      check_val("hold_rsp_vld", {31'd0, bus.up_rsp_vld}, 32'd1);
      check_val("hold_data", bus.up_rd_data, exp_data);
      check_val("hold_req_rdy", {31'd0, bus.up_req_rdy}, 32'd0);
    end
    bus.up_rsp_rdy = 1'b1;
    step();
    bus.up_rsp_rdy = 1'b0;
    check_val("rsp_vld_drop", {31'd0, bus.up_rsp_vld}, 32'd0);
  endtask

  // Access where the responder never acks; req_rdy is given once when use_rdy is set.
  task automatic timeout_xact(input logic [5:0] a, input logic use_rdy);
    int cnt;
    bus.up_req_vld = 1'b1;
    bus.up_wr      = 1'b0;
    bus.up_addr    = a;
    step();
    bus.up_req_vld = 1'b0;
    cnt = 0;
    if (use_rdy) begin
      bus.req_rdy = 1'b1;
      step();
      cnt++;
      bus.req_rdy = 1'b0;
    end
    while (!bus.up_rsp_vld && cnt < 200) begin
      step();
      cnt++;
    end
    check_val("tmo_cycles", cnt, 32'd64);
    check_val("tmo_err", {31'd0, bus.up_rsp_err}, 32'd1);
    check_val("tmo_data", bus.up_rd_data, 32'hDEAD_BEEF);
    check_val("tmo_req_vld", {31'd0, bus.req_vld}, 32'd0);
    check_val("tmo_rd_en", {31'd0, bus.rd_en}, 32'd0);
    bus.up_rsp_rdy = 1'b1;
    step();
    bus.up_rsp_rdy = 1'b0;
    check_val("tmo_idle", {31'd0, bus.up_req_rdy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.up_req_vld = 1'b0;
    bus.up_wr      = 1'b0;
    bus.up_addr    = 6'd0;
    bus.up_wr_data = 32'd0;
    bus.up_rsp_rdy = 1'b0;
    bus.req_rdy    = 1'b0;
    bus.rd_data    = 32'd0;
    bus.ack_vld    = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    step();
    step();
    check_val("rst_up_req_rdy", {31'd0, bus.up_req_rdy}, 32'd1);
    check_val("rst_rsp_vld", {31'd0, bus.up_rsp_vld}, 32'd0);
    check_val("rst_req_vld", {31'd0, bus.req_vld}, 32'd0);
    check_val("rst_ack_rdy", {31'd0, bus.ack_rdy}, 32'd0);
    check_val("rst_strobes", {30'd0, bus.wr_en, bus.rd_en}, 32'd0);
    check_val("rst_addr", {26'd0, bus.addr}, 32'd0);
    check_val("rst_rd_data", bus.up_rd_data, 32'd0);
    rst = 1'b0;
    step();

    // write then read back, minimum-latency responder
    xact(1'b1, 6'h05, 32'hA5A5_0001, 1, 0, 0, 32'h0000_0000, 4);
    xact(1'b0, 6'h05, 32'h0000_0000, 1, 0, 0, 32'hA5A5_0001, 4);
    // response stalled 10 cycles, late ack/req_rdy during the stall
    xact(1'b0, 6'h05, 32'h0000_0000, 1, 2, 10, 32'hA5A5_0001, 6);
    // req_rdy delayed 5 cycles
    xact(1'b1, 6'h2A, 32'h1234_5678, 5, 1, 0, 32'h0000_0000, 9);
    // ack on the same edge as req_rdy
    xact(1'b0, 6'h2A, 32'h0000_0000, 2, -1, 0, 32'h1234_5678, 4);

    // timeouts: stuck in REQ, and stuck in WAIT_ACK
    timeout_xact(6'h11, 1'b0);
    timeout_xact(6'h12, 1'b1);

    // reset while waiting for the ack
    bus.up_req_vld = 1'b1;
    bus.up_wr      = 1'b0;
    bus.up_addr    = 6'h07;
    step();
    bus.up_req_vld = 1'b0;
    bus.req_rdy    = 1'b1;
    step();
    bus.req_rdy = 1'b0;
    check_val("wait_ack_rdy", {31'd0, bus.ack_rdy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_req_rdy", {31'd0, bus.up_req_rdy}, 32'd1);
    check_val("mid_rst_ack_rdy", {31'd0, bus.ack_rdy}, 32'd0);
    check_val("mid_rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check_val("mid_rst_addr", {26'd0, bus.addr}, 32'd0);
    step();
    rst         = 1'b0;
    bus.ack_vld = 1'b1;
    bus.rd_data = 32'h7777_7777;
    step();
    bus.ack_vld = 1'b0;
    step();
    check_val("late_ack_rsp", {31'd0, bus.up_rsp_vld}, 32'd0);
    check_val("late_ack_idle", {31'd0, bus.up_req_rdy}, 32'd1);
    xact(1'b0, 6'h05, 32'h0000_0000, 1, 0, 0, 32'hA5A5_0001, 4);

    // fill memory with addr*3 then read every address back in order
    for (int a = 0; a < 64; a++)
      xact(1'b1, 6'(a), 32'(a) * 32'd3, 1, 0, 0, 32'h0000_0000, 4);
    for (int a = 0; a < 64; a++)
      xact(1'b0, 6'(a), 32'h0000_0000, 1, 0, 0, 32'(a) * 32'd3, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
